// File: rtl/render_display_list.sv
// render_display_list: walks a command list, runs rect/circle/triangle fill drawers, merges one pixel stream (x/y 1 cycle behind).
// oe low stalls the drawers in place; define RENDER_CLIP_EN to suppress pixels outside WIDTH x HEIGHT.
`timescale 1ns/1ps

// Bounding-box scan filler, one pixel per cycle; SHAPE 0 rect, 1 circle (centre x0,y0 radius x1), 2 triangle.
module draw_shape_fill #(
  parameter int CORDW = 16,
  parameter int SHAPE = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_oe,
  input  logic signed [CORDW-1:0] i_x0,
  input  logic signed [CORDW-1:0] i_y0,
  input  logic signed [CORDW-1:0] i_x1,
  input  logic signed [CORDW-1:0] i_y1,
  input  logic signed [CORDW-1:0] i_x2,
  input  logic signed [CORDW-1:0] i_y2,
  output logic signed [CORDW-1:0] o_x,
  output logic signed [CORDW-1:0] o_y,
  output logic                    o_drawing,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int EW = 2*CORDW + 4;

  logic signed [CORDW-1:0] r_x, r_y, r_xmin, r_xmax, r_ymax;
  logic signed [CORDW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic                    r_busy, r_done;
  logic signed [CORDW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [EW-1:0]    w_px, w_py, w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
  logic signed [EW-1:0]    w_dx, w_dy, w_e0, w_e1, w_e2;
  logic                    w_in;

  function automatic logic signed [CORDW-1:0] min2(input logic signed [CORDW-1:0] a,
                                                   input logic signed [CORDW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [CORDW-1:0] max2(input logic signed [CORDW-1:0] a,
                                                   input logic signed [CORDW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Twice the signed area of (a, b, p); zero on the edge itself, so edges are inclusive.
  function automatic logic signed [EW-1:0] edge_fn(input logic signed [EW-1:0] ax, ay, bx, by, px, py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  always_comb begin
    w_xmin = min2(i_x0, i_x1);
    w_xmax = max2(i_x0, i_x1);
    w_ymin = min2(i_y0, i_y1);
    w_ymax = max2(i_y0, i_y1);
    if (SHAPE == 1) begin
      w_xmin = i_x0 - i_x1;
      w_xmax = i_x0 + i_x1;
      w_ymin = i_y0 - i_x1;
      w_ymax = i_y0 + i_x1;
    end else if (SHAPE == 2) begin
      w_xmin = min2(w_xmin, i_x2);
      w_xmax = max2(w_xmax, i_x2);
      w_ymin = min2(w_ymin, i_y2);
      w_ymax = max2(w_ymax, i_y2);
    end
  end

  always_comb begin
    w_px = EW'(r_x);
    w_py = EW'(r_y);
    w_ax = EW'(r_x0);
    w_ay = EW'(r_y0);
    w_bx = EW'(r_x1);
    w_by = EW'(r_y1);
    w_cx = EW'(r_x2);
    w_cy = EW'(r_y2);
    w_dx = w_px - w_ax;
    w_dy = w_py - w_ay;
    w_e0 = edge_fn(w_ax, w_ay, w_bx, w_by, w_px, w_py);
    w_e1 = edge_fn(w_bx, w_by, w_cx, w_cy, w_px, w_py);
    w_e2 = edge_fn(w_cx, w_cy, w_ax, w_ay, w_px, w_py);
    case (SHAPE)
      1:       w_in = (w_dx * w_dx + w_dy * w_dy) <= (w_bx * w_bx);
      2:       w_in = (!w_e0[EW-1] && !w_e1[EW-1] && !w_e2[EW-1]) ||
                      ((w_e0[EW-1] || w_e0 == '0) && (w_e1[EW-1] || w_e1 == '0) &&
                       (w_e2[EW-1] || w_e2 == '0));
      default: w_in = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymax <= '0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_x1   <= '0;
      r_y1   <= '0;
      r_x2   <= '0;
      r_y2   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_x    <= w_xmin;
        r_y    <= w_ymin;
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_ymax <= w_ymax;
        r_x0   <= i_x0;
        r_y0   <= i_y0;
        r_x1   <= i_x1;
        r_y1   <= i_y1;
        r_x2   <= i_x2;
        r_y2   <= i_y2;
        r_busy <= 1'b1;
      end else if (r_busy && i_oe) begin
        if (r_x == r_xmax) begin
          r_x <= r_xmin;
          if (r_y == r_ymax) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_y <= r_y + 1'b1;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_drawing = r_busy && i_oe && w_in;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
endmodule

module render_display_list #(
  parameter  int CORDW      = 16,
  parameter  int CIDXW      = 4,
  parameter  int SCALE      = 1,
  parameter  int LIST_DEPTH = 256,
  parameter  int WIDTH      = 320,
  parameter  int HEIGHT     = 180,
  localparam int ADDRW      = $clog2(LIST_DEPTH),
  localparam int CMDW       = 3 + CIDXW + 6*CORDW
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_oe,
  input  logic                    i_start,
  input  logic [ADDRW-1:0]        i_list_base,
  output logic [ADDRW-1:0]        o_mem_addr,
  output logic                    o_mem_re,
  input  logic [CMDW-1:0]         i_mem_data,
  output logic signed [CORDW-1:0] o_x,
  output logic signed [CORDW-1:0] o_y,
  output logic [CIDXW-1:0]        o_cidx,
  output logic                    o_drawing,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_bad_op
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_DRAW, S_DONE} state_t;

  localparam logic [2:0] OP_END  = 3'd0;
  localparam logic [2:0] OP_RECT = 3'd1;
  localparam logic [2:0] OP_CIRC = 3'd2;
  localparam logic [2:0] OP_TRI  = 3'd3;
  localparam logic signed [CORDW-1:0] CLIP_W = CORDW'(WIDTH);
  localparam logic signed [CORDW-1:0] CLIP_H = CORDW'(HEIGHT);
`ifdef RENDER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  state_t                  r_state, w_next;
  logic [ADDRW-1:0]        r_ptr;
  logic [CMDW-1:0]         r_cmd;
  logic [CIDXW-1:0]        r_cidx;
  logic                    r_bad_op, r_any_done, r_drawing;
  logic signed [CORDW-1:0] r_x, r_y;
  logic [2:0]              w_op;
  logic                    w_last, w_start_rect, w_start_circ, w_start_tri;
  logic signed [CORDW-1:0] w_sx0, w_sy0, w_sx1, w_sy1, w_sx2, w_sy2;
  logic signed [CORDW-1:0] w_rect_x, w_rect_y, w_circ_x, w_circ_y, w_tri_x, w_tri_y, w_px, w_py;
  logic                    w_rect_drw, w_circ_drw, w_tri_drw;
  logic                    w_rect_busy, w_circ_busy, w_tri_busy;
  logic                    w_rect_done, w_circ_done, w_tri_done;
  logic                    w_visible;

  function automatic logic signed [CORDW-1:0] scale_c(input logic [CORDW-1:0] v);
    logic signed [CORDW+3:0] t;
    t = (CORDW+4)'($signed(v)) * (CORDW+4)'(SCALE);
    return t[CORDW-1:0];
  endfunction

  assign w_op   = r_cmd[CMDW-1 -: 3];
  assign w_sx0  = scale_c(r_cmd[5*CORDW +: CORDW]);
  assign w_sy0  = scale_c(r_cmd[4*CORDW +: CORDW]);
  assign w_sx1  = scale_c(r_cmd[3*CORDW +: CORDW]);
  assign w_sy1  = scale_c(r_cmd[2*CORDW +: CORDW]);
  assign w_sx2  = scale_c(r_cmd[CORDW +: CORDW]);
  assign w_sy2  = scale_c(r_cmd[0 +: CORDW]);
  assign w_last = (r_ptr == ADDRW'(LIST_DEPTH-1));

  always_comb begin
    w_next       = r_state;
    w_start_rect = 1'b0;
    w_start_circ = 1'b0;
    w_start_tri  = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_FETCH;
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_END:  w_next = S_DONE;
          OP_RECT: begin w_start_rect = 1'b1; w_next = S_DRAW; end
          OP_CIRC: begin w_start_circ = 1'b1; w_next = S_DRAW; end
          OP_TRI:  begin w_start_tri  = 1'b1; w_next = S_DRAW; end
          default: w_next = w_last ? S_DONE : S_FETCH;
        endcase
      end
      S_DRAW:   if (r_any_done) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The active drawer owns the pixel bus; only one is ever busy at a time.
  always_comb begin
    w_px = '0;
    w_py = '0;
    if (w_tri_busy) begin
      w_px = w_tri_x;
      w_py = w_tri_y;
    end else if (w_rect_busy) begin
      w_px = w_rect_x;
      w_py = w_rect_y;
    end else if (w_circ_busy) begin
      w_px = w_circ_x;
      w_py = w_circ_y;
    end
  end

  assign w_visible = !CLIP_EN ||
                     (!w_px[CORDW-1] && (w_px < CLIP_W) && !w_py[CORDW-1] && (w_py < CLIP_H));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cmd      <= '0;
      r_cidx     <= '0;
      r_bad_op   <= 1'b0;
      r_any_done <= 1'b0;
      r_drawing  <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_state    <= w_next;
      r_any_done <= w_rect_done | w_circ_done | w_tri_done;
      r_x        <= w_px;
      r_y        <= w_py;
      r_drawing  <= (w_rect_drw | w_circ_drw | w_tri_drw) && w_visible;
      if (r_state == S_IDLE && i_start) begin
        r_ptr    <= i_list_base;
        r_bad_op <= 1'b0;
      end else if (w_next == S_FETCH) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (r_state == S_WAIT) r_cmd <= i_mem_data;
      if (r_state == S_DECODE) begin
        if (w_op == OP_RECT || w_op == OP_CIRC || w_op == OP_TRI) r_cidx <= r_cmd[6*CORDW +: CIDXW];
        if (w_op[2] && w_op != 3'd4) r_bad_op <= 1'b1;
      end
    end
  end

  draw_shape_fill #(.CORDW(CORDW), .SHAPE(0)) u_rect (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_start_rect), .i_oe(i_oe),
    .i_x0(w_sx0), .i_y0(w_sy0), .i_x1(w_sx1), .i_y1(w_sy1), .i_x2(w_sx2), .i_y2(w_sy2),
    .o_x(w_rect_x), .o_y(w_rect_y), .o_drawing(w_rect_drw), .o_busy(w_rect_busy), .o_done(w_rect_done)
  );

  draw_shape_fill #(.CORDW(CORDW), .SHAPE(1)) u_circle (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_start_circ), .i_oe(i_oe),
    .i_x0(w_sx0), .i_y0(w_sy0), .i_x1(w_sx1), .i_y1(w_sy1), .i_x2(w_sx2), .i_y2(w_sy2),
    .o_x(w_circ_x), .o_y(w_circ_y), .o_drawing(w_circ_drw), .o_busy(w_circ_busy), .o_done(w_circ_done)
  );

  draw_shape_fill #(.CORDW(CORDW), .SHAPE(2)) u_triangle (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_start_tri), .i_oe(i_oe),
    .i_x0(w_sx0), .i_y0(w_sy0), .i_x1(w_sx1), .i_y1(w_sy1), .i_x2(w_sx2), .i_y2(w_sy2),
    .o_x(w_tri_x), .o_y(w_tri_y), .o_drawing(w_tri_drw), .o_busy(w_tri_busy), .o_done(w_tri_done)
  );

  assign o_mem_addr = r_ptr;
  assign o_mem_re   = (r_state == S_FETCH);
  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_cidx     = r_cidx;
  assign o_drawing  = r_drawing;
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done     = (r_state == S_DONE);
  assign o_bad_op   = r_bad_op;
endmodule
